// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and branch statistics.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 4,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    output logic [IDX_W-1:0] PredIdxF,
    input  logic             BranchE,
    input  logic [31:0]      PCE,
    input  logic [IDX_W-1:0] IdxE,
    input  logic             BranchTakenE,
    input  logic [31:0]      TargetE,
    input  logic             PredTakenE,
    input  logic [31:0]      PredTargetE,
    output logic             MispredictE,
    output logic [31:0]      BranchCnt,
    output logic [31:0]      MispredCnt
);
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic             validArr  [ENTRIES];
    logic [TAG_W-1:0] tagArr    [ENTRIES];
    logic [31:0]      targetArr [ENTRIES];
    logic [CTR_W-1:0] ctrArr    [ENTRIES];

    logic [IDX_W-1:0] pcIdx, lookIdx, updIdx;
    logic [TAG_W-1:0] pcTag, updTag;
    logic             hit, uHit, mispred;
    logic             unusedBits;

    assign pcIdx  = PCF[IDX_W+1:2];
    assign pcTag  = PCF[IDX_W+TAG_W+1:IDX_W+2];
    assign updTag = PCE[IDX_W+TAG_W+1:IDX_W+2];
    // PC bits outside index/tag fields carry no information for the table
    assign unusedBits = ^{PCF, PCE, IdxE};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] ghrFit;

    generate
        if (GHR_W >= IDX_W) begin : gTrunc
            assign ghrFit = ghr[IDX_W-1:0];
        end else begin : gExt
            assign ghrFit = {{(IDX_W-GHR_W){1'b0}}, ghr};
        end
    endgenerate

    assign lookIdx = pcIdx ^ ghrFit;
    assign updIdx  = IdxE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ghr <= '0;
        else if (BranchE)
            ghr <= {ghr[GHR_W-2:0], BranchTakenE};
    end
`else
    assign lookIdx = pcIdx;
    assign updIdx  = PCE[IDX_W+1:2];
`endif

    assign hit     = validArr[lookIdx] && (tagArr[lookIdx] == pcTag);
    assign uHit    = validArr[updIdx] && (tagArr[updIdx] == updTag);
    assign mispred = BranchE && ((PredTakenE != BranchTakenE) ||
                                 (BranchTakenE && (PredTargetE != TargetE)));

    // All outputs are forced low while reset is held
    assign PredTakenF  = reset && hit && ctrArr[lookIdx][CTR_W-1];
    assign PredTargetF = PredTakenF ? targetArr[lookIdx] : 32'h0;
    assign PredIdxF    = reset ? lookIdx : '0;
    assign MispredictE = reset && mispred;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i] <= 1'b0;
                ctrArr[i]   <= CTR_WNT;
            end
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else if (BranchE) begin
            if (uHit) begin
                if (BranchTakenE && ctrArr[updIdx] != CTR_MAX)
                    ctrArr[updIdx] <= ctrArr[updIdx] + 1'b1;
                else if (!BranchTakenE && ctrArr[updIdx] != '0)
                    ctrArr[updIdx] <= ctrArr[updIdx] - 1'b1;
            end else if (BranchTakenE) begin
                validArr[updIdx] <= 1'b1;
                ctrArr[updIdx]   <= CTR_WT;
            end
            if (BranchCnt != 32'hFFFF_FFFF)
                BranchCnt <= BranchCnt + 32'd1;
            if (mispred && MispredCnt != 32'hFFFF_FFFF)
                MispredCnt <= MispredCnt + 32'd1;
        end
    end

    // Tag/target need no reset: entries are guarded by validArr.
    // Rewriting the tag on a taken hit stores the same value.
    always_ff @(posedge clk) begin
        if (BranchE && BranchTakenE) begin
            tagArr[updIdx]    <= updTag;
            targetArr[updIdx] <= TargetE;
        end
    end
endmodule
